// File: rtl/cvita_pkt_gate_pkg.sv
// cvita_pkt_gate_pkg: shared types and helpers for the CVITA ingress packet gate.
package cvita_pkt_gate_pkg;
   typedef enum logic {WRITE, DROP} state_t;
   function automatic int ptr_w(input int size);
      return size + 1;
   endfunction
endpackage

// File: rtl/ram_2port.sv
// ram_2port: simple dual-port RAM, one write port and one registered read port with enable.
module ram_2port #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 9
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic              re,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);
   logic [DWIDTH-1:0] mem [2**AWIDTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/cvita_pkt_gate_in.sv
// cvita_pkt_gate_in: per-port ingress buffer that releases a packet only once its tlast is stored,
// dropping packets longer than the buffer.
module cvita_pkt_gate_in
   import cvita_pkt_gate_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int SIZE  = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] i_tdata,
   input  logic             i_tlast,
   input  logic             i_tvalid,
   output logic             i_tready,
   output logic [WIDTH-1:0] o_tdata,
   output logic             o_tlast,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic             pkt_present,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] drop_count
);
   localparam int PW = ptr_w(SIZE);
   localparam logic [PW-1:0] DEPTH = {1'b1, {SIZE{1'b0}}};

   state_t state, state_nxt;
   logic [PW-1:0] wr_spec, wr_commit, rd_ptr, fetch_ptr;
   logic [WIDTH:0] rd_data;
   logic [CNT_W-1:0] cnt_nxt;
   logic run, vld, full, oversize, acc, wr_en, commit, pop, hs, load;

   always_comb begin
      full      = (wr_spec - rd_ptr) == DEPTH;
      oversize  = state == WRITE && full && wr_commit == rd_ptr;
      i_tready  = run && !clear && (state == DROP || oversize || !full);
      acc       = i_tvalid && i_tready;
      wr_en     = acc && state == WRITE && !oversize;
      commit    = wr_en && i_tlast;
      o_tvalid  = vld && !clear;
      o_tdata   = o_tvalid ? rd_data[WIDTH-1:0] : '0;
      o_tlast   = o_tvalid && rd_data[WIDTH];
      hs        = o_tvalid && o_tready;
      pop       = hs && o_tlast;
      // the RAM read register is the output stage, so refetch only when it is empty or being taken
      load      = !clear && fetch_ptr != wr_commit && (!vld || o_tready);
      cnt_nxt   = pkt_count + CNT_W'(commit) - CNT_W'(pop);
      state_nxt = !acc ? state
                : state == DROP ? (i_tlast ? WRITE : DROP)
                : (oversize && !i_tlast) ? DROP : WRITE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run         <= 1'b0;
         state       <= WRITE;
         wr_spec     <= '0;
         wr_commit   <= '0;
         rd_ptr      <= '0;
         fetch_ptr   <= '0;
         vld         <= 1'b0;
         pkt_count   <= '0;
         pkt_present <= 1'b0;
         drop_count  <= '0;
      end else begin
         run <= 1'b1;
         if (clear) begin
            state       <= WRITE;
            wr_spec     <= '0;
            wr_commit   <= '0;
            rd_ptr      <= '0;
            fetch_ptr   <= '0;
            vld         <= 1'b0;
            pkt_count   <= '0;
            pkt_present <= 1'b0;
         end else begin
            state <= state_nxt;
            if (wr_en) wr_spec <= wr_spec + 1'b1;
            if (commit) wr_commit <= wr_spec + 1'b1;
            if (acc && oversize) begin
               wr_spec    <= wr_commit;
               drop_count <= drop_count + CNT_W'(~&drop_count);
            end
            if (hs) rd_ptr <= rd_ptr + 1'b1;
            if (load) fetch_ptr <= fetch_ptr + 1'b1;
            vld         <= load || (vld && !o_tready);
            pkt_count   <= cnt_nxt;
            pkt_present <= cnt_nxt != '0;
         end
      end
   end

   ram_2port #(.DWIDTH(WIDTH + 1), .AWIDTH(SIZE)) ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_spec[SIZE-1:0]),
      .wdata ({i_tlast, i_tdata}),
      .re    (load),
      .raddr (fetch_ptr[SIZE-1:0]),
      .rdata (rd_data)
   );
endmodule

// File: tb/tb_cvita_pkt_gate_in.sv
// tb_cvita_pkt_gate_in: packet-level reference model, table-driven packet vectors,
// directed corner sequences and randomized traffic for cvita_pkt_gate_in.
module tb_cvita_pkt_gate_in;
   localparam int W = 16;
   localparam int SZ = 4;
   localparam int CW = 5;
   localparam int DEPTH = 1 << SZ;
   localparam int DMAX = (1 << CW) - 1;

   logic clk = 1'b0, reset = 1'b1, clear = 1'b0;
   logic [W-1:0] i_tdata = '0, o_tdata;
   logic i_tlast = 1'b0, i_tvalid = 1'b0, i_tready;
   logic o_tlast, o_tvalid, o_tready = 1'b0, pkt_present;
   logic [CW-1:0] pkt_count, drop_count;

   cvita_pkt_gate_in #(.WIDTH(W), .SIZE(SZ), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .pkt_present(pkt_present), .pkt_count(pkt_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct { int len; int exp_out; int exp_drop; } vec_t;

   int checks = 0, errors = 0;
   int cyc = 0, n_out = 0, mcnt = 0, mdrop = 0, rmode = 0, gap = 0;
   int tl_cyc = -1, ov_rise = -1;
   logic ov_prev = 1'b0, in_acc = 1'b0;
   logic [W:0] expq[$];
   logic [W-1:0] cur[$], tx[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: compare against the model at the falling edge, then apply this cycle's handshakes.
   task automatic tick();
      @(negedge clk);
      chk("pkt_count", 32'(pkt_count), 32'(mcnt));
      chk("pkt_present", 32'(pkt_present), 32'(mcnt != 0));
      if (clear) begin
         chk("clear_i_tready", 32'(i_tready), 0);
         chk("clear_o_tvalid", 32'(o_tvalid), 0);
      end
      if (o_tvalid && !ov_prev) ov_rise = cyc;
      ov_prev = o_tvalid;
      if (o_tvalid) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_uncommitted: got %0h expected no valid word", {o_tlast, o_tdata});
         end else begin
            chk("out_word", 32'({o_tlast, o_tdata}), 32'(expq[0]));
            if (o_tready) begin
               if (expq[0][W]) mcnt--;
               void'(expq.pop_front());
               n_out++;
            end
         end
      end
      in_acc = i_tvalid && i_tready;
      if (in_acc) begin
         cur.push_back(i_tdata);
         if (i_tlast) begin
            tl_cyc = cyc;
            if (cur.size() <= DEPTH) begin
               foreach (cur[k]) expq.push_back({k == cur.size() - 1, cur[k]});
               mcnt++;
            end else if (mdrop < DMAX) mdrop++;
            cur.delete();
         end
      end
      if (clear) begin
         expq.delete();
         cur.delete();
         mcnt = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      o_tready = (rmode == 2) ? 1'($urandom_range(1)) : (rmode == 1);
   endtask

   task automatic gen(input int len);
      tx.delete();
      repeat (len) tx.push_back(W'($urandom));
   endtask

   task automatic send_words(input int from, input int to);
      int i = from, g = 0;
      while (i < to && g < 600) begin
         i_tvalid = ($urandom_range(99) >= gap);
         i_tdata  = tx[i];
         i_tlast  = (i == tx.size() - 1);
         tick();
         if (in_acc) i++;
         g++;
      end
      if (i < to) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got %0d words expected %0d", i, to);
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input int len);
      gen(len);
      send_words(0, len);
   endtask

   task automatic set_ready(input int m);
      rmode = m;
      o_tready = (m == 1);
   endtask

   task automatic drain();
      int g = 0;
      set_ready(1);
      while ((expq.size() != 0 || o_tvalid) && g < 300) begin
         tick();
         g++;
      end
      if (g >= 300) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d words left expected 0", expq.size());
      end
      repeat (2) tick();
   endtask

   task automatic chk_zero(input string p);
      chk({p, "_i_tready"}, 32'(i_tready), 0);
      chk({p, "_o_tvalid"}, 32'(o_tvalid), 0);
      chk({p, "_o_tlast"}, 32'(o_tlast), 0);
      chk({p, "_o_tdata"}, 32'(o_tdata), 0);
      chk({p, "_pkt_present"}, 32'(pkt_present), 0);
      chk({p, "_pkt_count"}, 32'(pkt_count), 0);
      chk({p, "_drop_count"}, 32'(drop_count), 0);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #3 reset = 1'b0;
      #1 chk("release_i_tready_low", 32'(i_tready), 0);
      @(posedge clk);
      #1 chk("release_i_tready_high", 32'(i_tready), 1);
      expq.delete();
      cur.delete();
      mcnt = 0;
      mdrop = 0;
      ov_prev = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[9];
      int o0, lat, tot;
      tbl = '{'{1, 1, 0}, '{4, 4, 0}, '{15, 15, 0}, '{16, 16, 0}, '{17, 0, 1},
              '{20, 0, 1}, '{3, 3, 0}, '{40, 0, 1}, '{2, 2, 0}};

      #12 chk_zero("reset");
      release_rst();

      // single 4-word packet, idle output: tlast-to-valid latency and in-order delivery
      set_ready(1);
      o0 = n_out;
      send_pkt(4);
      drain();
      lat = ov_rise - tl_cyc;
      checks++;
      if (lat < 2 || lat > 3) begin
         errors++;
         $display("FAIL latency: got %0d expected 2..3", lat);
      end
      chk("t1_words", 32'(n_out - o0), 4);

      // packet-length vectors from an empty buffer with the crossbar always ready
      tot = 0;
      foreach (tbl[v]) begin
         o0 = n_out;
         send_pkt(tbl[v].len);
         drain();
         tot += tbl[v].exp_drop;
         chk("tbl_words", 32'(n_out - o0), 32'(tbl[v].exp_out));
         chk("tbl_drop", 32'(drop_count), 32'(tot));
      end

      // buffer fills with committed packets, then backpressure
      set_ready(0);
      o0 = n_out;
      repeat (3) send_pkt(5);
      chk("t2_pkt_count", 32'(pkt_count), 3);
      gen(5);
      i_tvalid = 1'b1;
      i_tdata  = tx[0];
      i_tlast  = 1'b0;
      tick();
      chk("t2_16th_word_accepted", 32'(in_acc), 1);
      i_tdata = tx[1];
      repeat (3) begin
         tick();
         chk("t2_backpressure", 32'(in_acc), 0);
      end
      set_ready(1);
      send_words(1, 5);
      drain();
      chk("t2_words", 32'(n_out - o0), 20);

      // clear mid-packet: remainder becomes a new packet, drop_count retained
      set_ready(0);
      o0 = n_out;
      gen(6);
      send_words(0, 2);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      send_words(2, 6);
      tick();
      chk("t5_pkt_count", 32'(pkt_count), 1);
      chk("t5_drop_kept", 32'(drop_count), 32'(tot));
      drain();
      chk("t5_words", 32'(n_out - o0), 4);

      // randomized traffic against the packet-level model
      mdrop = tot;
      gap = 30;
      set_ready(2);
      repeat (30) send_pkt($urandom_range(1, 24));
      gap = 0;
      drain();
      chk("rand_drain_empty", 32'(expq.size()), 0);
      chk("rand_drop", 32'(drop_count), 32'(mdrop));

      // drop_count saturates
      set_ready(1);
      while (mdrop < DMAX) send_pkt(17);
      repeat (2) send_pkt(17);
      drain();
      chk("drop_saturated", 32'(drop_count), 32'(DMAX));

      // asynchronous reset mid-stream with a packet waiting at the output
      set_ready(0);
      send_pkt(3);
      repeat (3) tick();
      chk("pre_reset_o_tvalid", 32'(o_tvalid), 1);
      gen(4);
      i_tvalid = 1'b1;
      i_tdata  = tx[0];
      tick();
      #2 reset = 1'b1;
      #1 chk_zero("midreset");
      i_tvalid = 1'b0;
      repeat (2) @(posedge clk);
      release_rst();
      set_ready(1);
      o0 = n_out;
      send_pkt(2);
      drain();
      chk("post_reset_words", 32'(n_out - o0), 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cvita_pkt_gate_in.md
Name: cvita_pkt_gate_in

Overview:
Per-port ingress stage placed directly upstream of each crossbar input. Buffers CVITA packets on the AXI4-Stream bus and presents a packet downstream only after its tlast word is stored. This guarantees the crossbar never stalls mid-packet waiting on a slow source. Drives the crossbar pkt_present input and discards packets too long to fit in the buffer.

Parameters:
WIDTH, 64, tdata width in bits
SIZE, 10, log2 of buffer depth in words (depth = 2^SIZE)
CNT_W, 16, width of pkt_count and drop_count

Ports:
clk  input  1  clock; all logic in this domain
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous flush
i_tdata  input  WIDTH  upstream data
i_tlast  input  1  upstream end of packet
i_tvalid  input  1  upstream valid
i_tready  output  1  upstream ready
o_tdata  output  WIDTH  data to crossbar input
o_tlast  output  1  end of packet to crossbar
o_tvalid  output  1  valid to crossbar
o_tready  input  1  ready from crossbar
pkt_present  output  1  at least one complete packet held (to crossbar pkt_present)
pkt_count  output  CNT_W  complete packets held, not yet fully read
drop_count  output  CNT_W  oversize packets discarded; saturating

Behaviour:
- Reset values: i_tready=0, o_tvalid=0, o_tlast=0, o_tdata=0, pkt_present=0, pkt_count=0, drop_count=0; state=WRITE; all pointers 0. i_tready rises the first cycle after reset deasserts.
- Storage: 2^SIZE words of WIDTH+1 bits (tlast stored with the data).
- Pointers (SIZE+1 bits, wrap mod 2^(SIZE+1)):
  - wr_spec: next write.
  - wr_commit: start of the current incomplete packet.
  - rd_ptr: next word to free.
  - full = (wr_spec - rd_ptr) == 2^SIZE.
- State WRITE:
  - i_tready = !full, except in the oversize case below.
  - Accepted word is written at wr_spec, then wr_spec++.
  - Accepted tlast: wr_commit <= wr_spec+1 and pkt_count++. A packet of exactly 2^SIZE words fits and is committed.
- Oversize case: in WRITE with full && wr_commit==rd_ptr (no committed data left to drain):
  - i_tready=1; the word is accepted and discarded.
  - wr_spec <= wr_commit; drop_count++ (saturates at all-ones).
  - If that word has tlast, stay in WRITE; otherwise go to DROP.
- State DROP: i_tready=1; accept and discard words. On accepted tlast, go to WRITE. Nothing is written and no counter changes.
- Read side: RAM read is registered into an output stage.
  - Words in [rd_ptr, wr_commit) are readable.
  - o_tvalid may assert only for committed words.
  - Latency: tlast accepted at cycle N, so o_tvalid=1 no earlier than N+2 and no later than N+3 when the output is idle.
  - Handshake o_tvalid&&o_tready frees a word (rd_ptr++).
  - Once o_tvalid is high, o_tdata/o_tlast stay stable until accepted.
  - Back-to-back words stream at one per cycle while o_tready=1.
- pkt_count:
  - Increments on commit; decrements on output handshake with o_tlast=1.
  - Simultaneous commit and tlast handshake: unchanged.
- pkt_present = (pkt_count != 0), registered, updated the same cycle as pkt_count.
- clear:
  - Pointers, pkt_count, state=WRITE and the output stage go to 0/invalid next cycle; drop_count is retained.
  - During clear: i_tready=0, o_tvalid=0.
  - A partially received packet is lost; the remainder of that packet is then treated as a new packet.
- reset mid-operation: everything returns to reset values immediately (asynchronous), including drop_count.
- Full with committed data present: i_tready=0 (backpressure) until reads free space.

Decomposition:
- Package cvita_pkt_gate_pkg: state enum {WRITE, DROP} and a function for pointer width (SIZE+1).
- Storage uses the existing ram_2port (1 write port, 1 registered read port, width WIDTH+1, depth 2^SIZE) as the single sub-module.
- Pointer, FSM and output-stage logic live in cvita_pkt_gate_in.

Test Plan:
1. Single 4-word packet with o_tready=1 -> o_tvalid low until tlast stored; first output word at N+2..N+3; 4 words out with tlast on word 4; pkt_count 0->1->0; pkt_present matches.
2. o_tready=0, SIZE=4, three 5-word packets -> 16 words: first three packets accepted (15 words), fourth packet's 2nd word sees i_tready=0; pkt_count=3; releasing o_tready drains in order with no loss.
3. SIZE=4, one 20-word packet followed by a 3-word packet -> drop_count=1, nothing output for the first packet; the 3-word packet output intact; pkt_count peaks at 1.
4. SIZE=4, exact 16-word packet -> committed, not dropped; drop_count=0; 16 words out.
5. clear asserted after 2 of 6 words, then remaining 4 words with tlast -> 4-word packet output; pkt_count=1 before read; drop_count unchanged.
6. Assert reset mid-stream with drop_count=2 -> all outputs 0 asynchronously; drop_count=0; i_tready=1 one cycle after release.
